// File: rtl/fp_iter_cu.sv
// Control unit sequencing iterative FP datapaths (div, sqrt, ...): IDLE -> LOAD -> CALCULATE.
// Optional watchdog enabled by defining FP_ITER_CU_TIMEOUT_EN.
module fp_iter_cu #(
    parameter int NUM_UNITS  = 2,
    parameter int SEL_W      = 1,
    parameter int MAX_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 startOp,
    input  logic [SEL_W-1:0]     opSel,
    input  logic                 abortOp,
    input  logic [NUM_UNITS-1:0] readyUnit,
    output logic [NUM_UNITS-1:0] load,
    output logic                 finishOp,
    output logic                 doneOk,
    output logic                 errFlag,
    output logic [CNT_W-1:0]     cycleCount
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD      = 2'b01,
        CALCULATE = 2'b10
    } state_t;

    if (NUM_UNITS < 1 || NUM_UNITS > 16 || (2 ** SEL_W) < NUM_UNITS ||
        MAX_CYCLES < 2 || MAX_CYCLES > (2 ** CNT_W)) begin : g_bad_params
        $error("fp_iter_cu: illegal parameter combination");
    end

    state_t               state, state_nx;
    logic [SEL_W-1:0]     sel_reg, sel_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx, cnt_inc;
    logic                 err, err_nx;
    logic                 done_r, done_nx;
    logic [NUM_UNITS-1:0] sel_hot;
    logic                 sel_ready, start_ok, timeout;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++)
            sel_hot[i] = (sel_reg == SEL_W'(i));
    end

    // Only the selected unit's ready flag can complete the operation.
    assign sel_ready = |(readyUnit & sel_hot);
    assign start_ok  = {{(32-SEL_W){1'b0}}, opSel} < 32'(NUM_UNITS);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef FP_ITER_CU_TIMEOUT_EN
    assign timeout = (cnt == CNT_W'(MAX_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = IDLE;
        sel_nx   = sel_reg;
        cnt_nx   = cnt;
        err_nx   = err;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (startOp) begin
                    if (start_ok) begin
                        state_nx = LOAD;
                        sel_nx   = opSel;
                        err_nx   = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            LOAD: state_nx = abortOp ? IDLE : CALCULATE;
            CALCULATE: begin
                // Abort beats ready, ready beats timeout; a timeout keeps the count at the limit.
                if (abortOp) begin
                    cnt_nx = cnt_inc;
                end else if (sel_ready) begin
                    done_nx = 1'b1;
                    cnt_nx  = cnt_inc;
                end else if (timeout) begin
                    err_nx = 1'b1;
                end else begin
                    state_nx = CALCULATE;
                    cnt_nx   = cnt_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel_reg <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            sel_reg <= sel_nx;
            cnt     <= cnt_nx;
            err     <= err_nx;
            done_r  <= done_nx;
        end
    end

    assign load       = (state == LOAD) ? sel_hot : '0;
    assign finishOp   = (state != LOAD) && (state != CALCULATE);
    assign doneOk     = done_r;
    assign errFlag    = err;
    assign cycleCount = cnt;

endmodule
